// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI mode decode, FSM state encoding and bit-count width
package spi_pkg;

  localparam int BIT_CNT_W = 3;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = 3'd7;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // CPOL is the upper bit of the mode number
  function automatic logic mode_cpol(input int mode);
    return mode[1];
  endfunction

  // CPHA is the lower bit of the mode number
  function automatic logic mode_cpha(input int mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI responder byte handshake and pin bundle; SPI_SLAVE_STATUS_EN adds status pulses
interface spi_slave_if;
  logic [7:0] i_TX_Byte;
  logic       i_TX_DV;
  logic       o_TX_Ready;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       i_SPI_clk;
  logic       i_SPI_CS_n;
  logic       i_SPI_MOSI;
  logic       o_SPI_MISO;
  logic       o_SPI_MISO_En;
`ifdef SPI_SLAVE_STATUS_EN
  logic       o_TX_Underrun;
  logic       o_RX_Abort;
`endif

  modport slave (
`ifdef SPI_SLAVE_STATUS_EN
    output o_TX_Underrun, output o_RX_Abort,
`endif
    input  i_TX_Byte, input i_TX_DV, output o_TX_Ready,
    output o_RX_DV, output o_RX_Byte,
    input  i_SPI_clk, input i_SPI_CS_n, input i_SPI_MOSI,
    output o_SPI_MISO, output o_SPI_MISO_En
  );

  modport master (
`ifdef SPI_SLAVE_STATUS_EN
    input  o_TX_Underrun, input o_RX_Abort,
`endif
    output i_TX_Byte, output i_TX_DV, input o_TX_Ready,
    input  o_RX_DV, input o_RX_Byte,
    output i_SPI_clk, output i_SPI_CS_n, output i_SPI_MOSI,
    input  o_SPI_MISO, input o_SPI_MISO_En
  );
endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchroniser with rise/fall pulses on the synchronised level
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // shift the async input through the chain and keep the previous synchronised sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI responder; define SPI_SLAVE_STATUS_EN for o_TX_Underrun/o_RX_Abort
module spi_slave import spi_pkg::*; #(
  parameter int         SPI_MODE     = 0,
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] IDLE_TX_BYTE = 8'hFF
) (
  input  logic     i_clk,
  input  logic     i_rst,
  spi_slave_if.slave bus
);

  localparam logic CPOL = mode_cpol(SPI_MODE);
  localparam logic CPHA = mode_cpha(SPI_MODE);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_s;
  logic lead, trail, sample_raw, drive_raw;
  state_t state, state_next;
  logic entry, leave, do_sample, do_drive, load;
  logic [7:0] load_byte, hold_byte, tx_shift, rx_shift, rx_next, rx_byte;
  logic hold_full, rx_dv, miso;
  logic [BIT_CNT_W-1:0] bit_cnt;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
    .clk(i_clk), .rst(i_rst), .din(bus.i_SPI_clk), .rise(sclk_rise), .fall(sclk_fall));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(i_clk), .rst(i_rst), .din(bus.i_SPI_CS_n), .rise(cs_rise), .fall(cs_fall));

  // MOSI delayed by the same depth so it lines up with the synchronised SCLK edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) mosi_chain <= '0;
    else       mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], bus.i_SPI_MOSI};
  end
  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  assign lead       = CPOL ? sclk_fall : sclk_rise;
  assign trail      = CPOL ? sclk_rise : sclk_fall;
  assign sample_raw = CPHA ? trail : lead;
  assign drive_raw  = CPHA ? lead : trail;

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state: CS edges move between IDLE and ACTIVE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = ACTIVE;
      ACTIVE:  if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: SCLK edges only count while selected and not leaving
  always_comb begin
    entry     = 1'b0;
    leave     = 1'b0;
    do_sample = 1'b0;
    do_drive  = 1'b0;
    case (state)
      IDLE:   entry = cs_fall;
      ACTIVE: begin
        leave     = cs_rise;
        do_sample = sample_raw & ~cs_rise;
        do_drive  = drive_raw & ~cs_rise;
      end
      default: ;
    endcase
  end

  assign load      = entry | (do_sample & (bit_cnt == '0));
  assign load_byte = hold_full ? hold_byte : (bus.i_TX_DV ? bus.i_TX_Byte : IDLE_TX_BYTE);

  // holding register: a byte arriving on a load cycle with nothing pending bypasses it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_full <= 1'b0;
      hold_byte <= '0;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end else if (bus.i_TX_DV && !hold_full && !load) begin
      hold_full <= 1'b1;
      hold_byte <= bus.i_TX_Byte;
    end
  end

  // TX shifter: CPHA=0 presents the MSB right at CS entry, otherwise bits leave on drive edges
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      miso     <= 1'b0;
      tx_shift <= '0;
    end else if (leave) begin
      miso <= 1'b0;
    end else if (load) begin
      if (entry && !CPHA) {miso, tx_shift} <= {load_byte, 1'b0};
      else                tx_shift <= load_byte;
    end else if (do_drive) begin
      {miso, tx_shift} <= {tx_shift, 1'b0};
    end
  end

  // receive bit written at the counter position
  always_comb begin
    rx_next          = rx_shift;
    rx_next[bit_cnt] = mosi_s;
  end

  // RX sampling, byte completion and partial-byte discard on CS release
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt  <= BIT_CNT_MAX;
      rx_shift <= '0;
      rx_dv    <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_dv <= 1'b0;
      if (leave) begin
        bit_cnt <= BIT_CNT_MAX;
      end else if (do_sample) begin
        rx_shift <= rx_next;
        if (bit_cnt == '0) begin
          rx_byte <= rx_next;
          rx_dv   <= 1'b1;
          bit_cnt <= BIT_CNT_MAX;
        end else begin
          bit_cnt <= bit_cnt - BIT_CNT_W'(1);
        end
      end
    end
  end

  assign bus.o_TX_Ready    = ~hold_full;
  assign bus.o_RX_DV       = rx_dv;
  assign bus.o_RX_Byte     = rx_byte;
  assign bus.o_SPI_MISO    = miso;
  assign bus.o_SPI_MISO_En = (state == ACTIVE);

`ifdef SPI_SLAVE_STATUS_EN
  logic underrun, rx_abort;

  // status pulses: idle byte substituted, or CS released mid-byte
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      underrun <= 1'b0;
      rx_abort <= 1'b0;
    end else begin
      underrun <= load & ~hold_full & ~bus.i_TX_DV;
      rx_abort <= leave & (bit_cnt != BIT_CNT_MAX);
    end
  end

  assign bus.o_TX_Underrun = underrun;
  assign bus.o_RX_Abort    = rx_abort;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard bench for spi_slave across all four SPI modes
module tb_spi_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] cur_mode;
  logic       cpol, cpha;
  logic       sclk, cs_n, mosi, tx_dv;
  logic [7:0] tx_byte;

  logic       rx_dv_a [4];
  logic [7:0] rx_byte_a [4];
  logic       tx_ready_a [4];
  logic       miso_a [4];
  logic       miso_en_a [4];
`ifdef SPI_SLAVE_STATUS_EN
  logic       und_a [4];
  logic       abort_a [4];
`endif

  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_slave_if bus();
    assign bus.i_SPI_clk  = (cur_mode == 2'(m)) ? sclk : (m >= 2);
    assign bus.i_SPI_CS_n = (cur_mode == 2'(m)) ? cs_n : 1'b1;
    assign bus.i_SPI_MOSI = mosi;
    assign bus.i_TX_Byte  = tx_byte;
    assign bus.i_TX_DV    = (cur_mode == 2'(m)) & tx_dv;
    assign rx_dv_a[m]     = bus.o_RX_DV;
    assign rx_byte_a[m]   = bus.o_RX_Byte;
    assign tx_ready_a[m]  = bus.o_TX_Ready;
    assign miso_a[m]      = bus.o_SPI_MISO;
    assign miso_en_a[m]   = bus.o_SPI_MISO_En;
`ifdef SPI_SLAVE_STATUS_EN
    assign und_a[m]       = bus.o_TX_Underrun;
    assign abort_a[m]     = bus.o_RX_Abort;
`endif
    spi_slave #(.SPI_MODE(m), .SYNC_STAGES(2), .IDLE_TX_BYTE(8'hFF)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus.slave));
  end

  logic       rx_dv, tx_ready, miso, miso_en;
  logic [7:0] rx_byte;
  assign rx_dv    = rx_dv_a[cur_mode];
  assign rx_byte  = rx_byte_a[cur_mode];
  assign tx_ready = tx_ready_a[cur_mode];
  assign miso     = miso_a[cur_mode];
  assign miso_en  = miso_en_a[cur_mode];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_dv === 1'b1) begin
      if (exp_rx.size() == 0) check("rx_dv_unexpected", 32'd1, 32'd0);
      else                    check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_rx.pop_front()});
    end
  end

`ifdef SPI_SLAVE_STATUS_EN
  int und_cnt = 0;
  int abort_cnt = 0;
  always @(negedge clk) begin
    if (und_a[cur_mode] === 1'b1) und_cnt++;
    if (abort_a[cur_mode] === 1'b1) abort_cnt++;
  end
`endif

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] b);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("tx_ready_timeout", 32'd0, 32'd1);
    tx_byte = b;
    tx_dv   = 1'b1;
    @(negedge clk);
    tx_dv   = 1'b0;
    exp_miso.push_back(b);
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    half();
  endtask

  task automatic cs_end();
    half();
    cs_n = 1'b1;
    half();
    half();
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, input logic do_check);
    logic [7:0] got;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = tx[7-i];
        half();
        sclk = ~cpol;
        got[7-i] = miso;
        half();
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = tx[7-i];
        half();
        sclk = cpol;
        got[7-i] = miso;
        half();
      end
    end
    if (do_check) begin
      if (exp_miso.size() == 0) check("miso_unexpected", 32'd1, 32'd0);
      else                      check("miso_byte", {24'd0, got}, {24'd0, exp_miso.pop_front()});
    end
  endtask

  task automatic byte_xfer(input logic [7:0] m);
    exp_rx.push_back(m);
    xfer(m, 8, 1'b1);
  endtask

  task automatic set_mode(input logic [1:0] m);
    sclk     = m[1];
    cpol     = m[1];
    cpha     = m[0];
    cur_mode = m;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
    check({tag, "_rx_dv"},    {31'd0, rx_dv},    32'd0);
    check({tag, "_rx_byte"},  {24'd0, rx_byte},  32'd0);
    check({tag, "_miso"},     {31'd0, miso},     32'd0);
    check({tag, "_miso_en"},  {31'd0, miso_en},  32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SPI_SLAVE_STATUS_EN
    int base;
`endif
    cur_mode = 2'd0; cpol = 1'b0; cpha = 1'b0;
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_dv = 1'b0; tx_byte = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // mode 0 basic exchange
    load_tx(8'hA5);
    check("ready_full", {31'd0, tx_ready}, 32'd0);
    cs_begin();
    check("ready_after_entry", {31'd0, tx_ready}, 32'd1);
    check("miso_en_active", {31'd0, miso_en}, 32'd1);
    byte_xfer(8'h3C);
    cs_end();
    check("rx_pending_basic", exp_rx.size(), 32'd0);
    check("miso_en_idle", {31'd0, miso_en}, 32'd0);

    // nothing loaded: idle byte returned
    exp_miso.push_back(8'hFF);
`ifdef SPI_SLAVE_STATUS_EN
    base = und_cnt;
`endif
    cs_begin();
`ifdef SPI_SLAVE_STATUS_EN
    check("underrun_entry", und_cnt - base, 32'd1);
`endif
    byte_xfer(8'h55);
    cs_end();

    // three bytes in one window with refills
    load_tx(8'hD1);
    cs_begin();
    load_tx(8'hD2);
    byte_xfer(8'h01);
    load_tx(8'hD3);
    byte_xfer(8'h02);
    byte_xfer(8'h03);
    cs_end();
    check("rx_pending_burst", exp_rx.size(), 32'd0);

    // CS released after four bits
`ifdef SPI_SLAVE_STATUS_EN
    base = abort_cnt;
`endif
    cs_begin();
    xfer(8'hF0, 4, 1'b0);
    cs_end();
    check("rx_hold_after_abort", {24'd0, rx_byte}, 32'h03);
`ifdef SPI_SLAVE_STATUS_EN
    check("rx_abort", abort_cnt - base, 32'd1);
`endif
    exp_miso.push_back(8'hFF);
    cs_begin();
    byte_xfer(8'hC3);
    cs_end();

    // DV while holding register full is dropped
    load_tx(8'h5A);
    tx_byte = 8'hEE;
    tx_dv   = 1'b1;
    @(negedge clk);
    tx_dv   = 1'b0;
    check("ready_ignored_dv", {31'd0, tx_ready}, 32'd0);
    cs_begin();
    byte_xfer(8'h99);
    cs_end();

    // reset mid-byte
    cs_begin();
    xfer(8'hAA, 3, 1'b0);
    rst  = 1'b1;
    cs_n = 1'b1;
    sclk = cpol;
    @(negedge clk);
    check_reset_values("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_values("after_reset");
    load_tx(8'h42);
    cs_begin();
    byte_xfer(8'h24);
    cs_end();

    // remaining modes
    for (int m = 1; m < 4; m++) begin
      set_mode(2'(m));
      load_tx(8'h7E);
      cs_begin();
      byte_xfer(8'h81);
      cs_end();
      check("rx_pending_mode", exp_rx.size(), 32'd0);
    end

    check("miso_queue_empty", exp_miso.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
